// File: rtl/iccm_ctrl_pkg.sv
// Shared types and defaults for the boot-time ICCM loader.
package iccm_ctrl_pkg;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } iccm_ctrl_state_e;

  localparam int unsigned ICCM_ADDR_W_DEFAULT     = 12;
  localparam logic [31:0] ICCM_END_MARKER_DEFAULT = 32'h0000_0FFF;

endpackage

// File: rtl/iccm_word_assembler.sv
// Packs UART bytes little-endian into 32-bit words; optional partial-word
// idle timeout is built when ICCM_CTRL_TIMEOUT_EN is defined.
module iccm_word_assembler #(
  parameter int unsigned TimeoutCycles = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        run_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o,
  output logic        timeout_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] asm_q, asm_d;
  logic        tmo_fire;

`ifdef ICCM_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          tmo_q, tmo_d;

  // Down-counter reloaded on every accepted byte; fires at terminal count 1.
  always_comb begin
    tmr_d    = tmr_q;
    tmo_fire = 1'b0;
    if (clear_i || valid_i) begin
      tmr_d = TW'(TimeoutCycles);
    end else if (run_i && (cnt_q != 2'd0)) begin
      if (tmr_q == TW'(1)) begin
        tmo_fire = 1'b1;
        tmr_d    = TW'(TimeoutCycles);
      end else begin
        tmr_d = tmr_q - TW'(1);
      end
    end
    tmo_d = tmo_fire;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmr_q <= TW'(TimeoutCycles);
      tmo_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles != 0) & run_i;
  assign tmo_fire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (clear_i || tmo_fire) begin
      cnt_d = 2'd0;
      asm_d = '0;
    end else if (valid_i) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    asm_d[7:0]   = byte_i;
        2'd1:    asm_d[15:8]  = byte_i;
        2'd2:    asm_d[23:16] = byte_i;
        default: asm_d        = asm_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

  // The fourth byte goes straight into the word so the top can latch it this cycle.
  assign word_o      = {byte_i, asm_q};
  assign word_done_o = valid_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/iccm_controller.sv
// Boot-time ICCM loader: writes assembled UART words from address 0 and holds
// the core in reset until the end marker or a full ICCM. Option: ICCM_CTRL_TIMEOUT_EN.
//
// state | meaning
// RECV  | collecting bytes of the next word
// WRITE | one-cycle write strobe to the ICCM
// DONE  | programming finished, core released
module iccm_controller
  import iccm_ctrl_pkg::*;
#(
  parameter int unsigned AddrW         = ICCM_ADDR_W_DEFAULT,
  parameter logic [31:0] EndMarker     = ICCM_END_MARKER_DEFAULT,
  parameter int unsigned TimeoutCycles = 100000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       rx_byte_i,
  input  logic             rx_valid_i,
  input  logic             restart_i,
  output logic [AddrW-1:0] iccm_ctrl_addr_o,
  output logic [31:0]      iccm_ctrl_wdata_o,
  output logic             iccm_ctrl_we_o,
  output logic             prog_rst_no,
  output logic             done_o,
  output logic             timeout_o
);

  iccm_ctrl_state_e state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             done_q, done_d;

  logic        accept, clear, word_done;
  logic [31:0] word;
  logic        addr_full;

  assign accept    = rx_valid_i && (state_q != DONE);
  assign clear     = restart_i && (state_q == DONE);
  assign addr_full = (addr_q == {AddrW{1'b1}});

  iccm_word_assembler #(
    .TimeoutCycles (TimeoutCycles)
  ) u_asm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear),
    .run_i       (state_q == RECV),
    .valid_i     (accept),
    .byte_i      (rx_byte_i),
    .word_o      (word),
    .word_done_o (word_done),
    .timeout_o   (timeout_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RECV;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RECV:    if (word_done) state_d = (word == EndMarker) ? DONE : WRITE;
      WRITE:   state_d = addr_full ? DONE : RECV;
      DONE:    if (restart_i) state_d = RECV;
      default: state_d = RECV;
    endcase
  end

  // Output registers are loaded from the next state so every output is a flop.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == WRITE && !addr_full) addr_d = addr_q + AddrW'(1);
    if (clear) addr_d = '0;
    if (state_q == RECV && word_done && word != EndMarker) wdata_d = word;
    we_d   = (state_d == WRITE);
    done_d = (state_d == DONE);
  end

  assign iccm_ctrl_addr_o  = addr_q;
  assign iccm_ctrl_wdata_o = wdata_q;
  assign iccm_ctrl_we_o    = we_q;
  assign done_o            = done_q;
  assign prog_rst_no       = done_q;

endmodule

// File: tb/tb_iccm_controller.sv
// Directed bench for iccm_controller: default instance plus a 4-word ICCM instance.
module tb_iccm_controller;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i, rx_valid_i, restart_i;
  logic [7:0]  rx_byte_i;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        we, prog, done, tmo;

  logic        s_rst, s_valid, s_restart;
  logic [7:0]  s_byte;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic        s_we, s_prog, s_done, s_tmo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  s_addrs[$];
  logic [31:0] s_datas[$];

  iccm_controller #(.TimeoutCycles(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_byte_i(rx_byte_i), .rx_valid_i(rx_valid_i),
    .restart_i(restart_i), .iccm_ctrl_addr_o(addr), .iccm_ctrl_wdata_o(wdata),
    .iccm_ctrl_we_o(we), .prog_rst_no(prog), .done_o(done), .timeout_o(tmo)
  );

  iccm_controller #(.AddrW(2), .TimeoutCycles(10)) dut_s (
    .clk_i(clk_i), .rst_i(s_rst), .rx_byte_i(s_byte), .rx_valid_i(s_valid),
    .restart_i(s_restart), .iccm_ctrl_addr_o(s_addr), .iccm_ctrl_wdata_o(s_wdata),
    .iccm_ctrl_we_o(s_we), .prog_rst_no(s_prog), .done_o(s_done), .timeout_o(s_tmo)
  );

  always @(negedge clk_i) begin
    if (s_we) begin
      s_addrs.push_back(s_addr);
      s_datas.push_back(s_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic mb(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_byte_i  = b;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic sword(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_byte  = w[8*i +: 8];
      tick();
    end
    s_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst_i = 1'b1; rx_valid_i = 1'b0; rx_byte_i = 8'h00; restart_i = 1'b0;
    s_rst = 1'b1; s_valid = 1'b0; s_byte = 8'h00; s_restart = 1'b0;
    tick(); tick();
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_we", 32'(we), 32'h0);
    check("rst_prog", 32'(prog), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_tmo", 32'(tmo), 32'h0);
    rst_i = 1'b0; s_rst = 1'b0;

    mb(8'h78); mb(8'h56); mb(8'h34);
    check("w0_we_early", 32'(we), 32'h0);
    mb(8'h12);
    check("w0_we", 32'(we), 32'h1);
    check("w0_addr", 32'(addr), 32'h0);
    check("w0_data", wdata, 32'h1234_5678);
    check("w0_prog", 32'(prog), 32'h0);
    tick();
    check("w0_we_drop", 32'(we), 32'h0);
    check("w0_addr_inc", 32'(addr), 32'h1);

    mb(8'hD4); mb(8'hC3); mb(8'hB2); mb(8'hA1);
    check("w1_we", 32'(we), 32'h1);
    check("w1_addr", 32'(addr), 32'h1);
    check("w1_data", wdata, 32'hA1B2_C3D4);
    mb(8'h11);
    check("w2_byte_in_write_we", 32'(we), 32'h0);
    check("w2_addr_inc", 32'(addr), 32'h2);
    mb(8'h22); mb(8'h33); mb(8'h44);
    check("w2_we", 32'(we), 32'h1);
    check("w2_addr", 32'(addr), 32'h2);
    check("w2_data", wdata, 32'h4433_2211);
    mb(8'hFF);
    check("em_addr", 32'(addr), 32'h3);
    mb(8'h0F); mb(8'h00);
    check("em_done_early", 32'(done), 32'h0);
    mb(8'h00);
    check("em_done", 32'(done), 32'h1);
    check("em_prog", 32'(prog), 32'h1);
    check("em_no_write", 32'(we), 32'h0);
    check("em_addr_hold", 32'(addr), 32'h3);

    mb(8'h01); mb(8'h02); mb(8'h03); mb(8'h04);
    tick();
    check("done_ignore_we", 32'(we), 32'h0);
    check("done_ignore_data", wdata, 32'h4433_2211);
    check("done_hold", 32'(done), 32'h1);

    restart_i = 1'b1; tick(); restart_i = 1'b0;
    check("rs_done", 32'(done), 32'h0);
    check("rs_prog", 32'(prog), 32'h0);
    check("rs_addr", 32'(addr), 32'h0);
    mb(8'hBE); mb(8'hBA); mb(8'hFE); mb(8'hCA);
    check("rs_we", 32'(we), 32'h1);
    check("rs_waddr", 32'(addr), 32'h0);
    check("rs_data", wdata, 32'hCAFE_BABE);
    tick();

    mb(8'h11); mb(8'h22);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    check("mrst_addr", 32'(addr), 32'h0);
    check("mrst_wdata", wdata, 32'h0);
    check("mrst_we", 32'(we), 32'h0);
    check("mrst_prog", 32'(prog), 32'h0);
    mb(8'h55); mb(8'h66); mb(8'h77); mb(8'h88);
    check("mrst_w_we", 32'(we), 32'h1);
    check("mrst_w_addr", 32'(addr), 32'h0);
    check("mrst_w_data", wdata, 32'h8877_6655);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    check("wrst_we", 32'(we), 32'h0);
    check("wrst_addr", 32'(addr), 32'h0);
    check("wrst_wdata", wdata, 32'h0);
    mb(8'h99); mb(8'hAA); mb(8'hBB); mb(8'hCC);
    check("wrst_w_addr", 32'(addr), 32'h0);
    check("wrst_w_data", wdata, 32'hCCBB_AA99);
    tick();
    check("wrst_addr_inc", 32'(addr), 32'h1);

    mb(8'h01); mb(8'h02);
`ifdef ICCM_CTRL_TIMEOUT_EN
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("tmo_idle%0d", i), 32'(tmo), (i == 10) ? 32'h1 : 32'h0);
    end
    tick();
    check("tmo_pulse_end", 32'(tmo), 32'h0);
    mb(8'hAA); mb(8'hBB); mb(8'hCC); mb(8'hDD);
    check("tmo_w_we", 32'(we), 32'h1);
    check("tmo_w_addr", 32'(addr), 32'h1);
    check("tmo_w_data", wdata, 32'hDDCC_BBAA);
`else
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("notmo_idle%0d", i), 32'(tmo), 32'h0);
    end
    mb(8'hAA); mb(8'hBB);
    check("notmo_w_we", 32'(we), 32'h1);
    check("notmo_w_addr", 32'(addr), 32'h1);
    check("notmo_w_data", wdata, 32'hBBAA_0201);
`endif
    tick();

    for (int w = 1; w <= 5; w++) sword(32'(w));
    check("full_nwrites", 32'(s_addrs.size()), 32'd4);
    for (int i = 0; i < 4 && i < s_addrs.size(); i++) begin
      check($sformatf("full_addr%0d", i), 32'(s_addrs[i]), 32'(i));
      check($sformatf("full_data%0d", i), s_datas[i], 32'(i + 1));
    end
    check("full_done", 32'(s_done), 32'h1);
    check("full_prog", 32'(s_prog), 32'h1);
    check("full_addr_hold", 32'(s_addr), 32'h3);
    check("full_we_low", 32'(s_we), 32'h0);
    s_restart = 1'b1; tick(); s_restart = 1'b0;
    check("full_rs_done", 32'(s_done), 32'h0);
    sword(32'h0000_0077);
    check("full_rs_nwrites", 32'(s_addrs.size()), 32'd5);
    if (s_addrs.size() == 5) begin
      check("full_rs_addr", 32'(s_addrs[4]), 32'h0);
      check("full_rs_data", s_datas[4], 32'h0000_0077);
    end
    check("small_tmo", 32'(s_tmo), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iccm_controller.md
# iccm_controller

Boot-time ICCM loader sitting directly upstream of the instruction-memory top. Takes a byte stream from the UART receiver, assembles little-endian 32-bit words, and writes them sequentially from ICCM word address 0 through the controller write port of the instruction memory. Holds the core in program-reset (`prog_rst_no` low) until an end-of-program marker arrives or the ICCM fills. The instruction-memory top then hands the SRAM back to the TL-UL path.

## Interface
- `AddrW`, default 12: ICCM word-address width.
- `EndMarker`, default 32'h0000_0FFF: terminating word; it is never written.
- `TimeoutCycles`, default 100000: idle limit for a partial word. Used only with the timeout macro.
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset. Synchronous, active-high.
- `rx_byte_i`, input, 8: received byte.
- `rx_valid_i`, input, 1: one-cycle strobe; `rx_byte_i` is valid in that cycle.
- `restart_i`, input, 1: pulse; restarts programming from address 0. Honoured only in DONE.
- `iccm_ctrl_addr_o`, output, AddrW: ICCM word address.
- `iccm_ctrl_wdata_o`, output, 32: assembled word.
- `iccm_ctrl_we_o`, output, 1: write strobe, one cycle per word.
- `prog_rst_no`, output, 1: 0 means the core is held and the ICCM is owned by this block.
- `done_o`, output, 1: level; programming complete.
- `timeout_o`, output, 1: one-cycle pulse when a partial word is discarded. Constant 0 without the macro.

## Operation
- States:
  - RECV: collecting bytes.
  - WRITE: one cycle, drives the write.
  - DONE: programming finished.
- Reset enters RECV with all outputs cleared (see Timing for values).
- Byte assembly:
  - A 2-bit byte counter selects the lane; the first byte of a word goes to [7:0], the fourth to [31:24].
  - The counter wraps 3→0 when the fourth byte is accepted.
- On acceptance of the fourth byte:
  - If the word equals `EndMarker`: go to DONE. No write occurs and the address does not change.
  - Otherwise: latch the word into the output register and go to WRITE.
- WRITE:
  - `iccm_ctrl_we_o` = 1 for exactly one cycle, with the current address and the latched data.
  - Next state is RECV.
  - The address increments when WRITE exits.
- Bytes arriving during WRITE are accepted into the next word. The assembly register is separate from the output register, so no byte is lost.
- Memory full: when WRITE completes at address 2^AddrW−1, go to DONE instead of RECV. The address does not wrap.
- DONE:
  - `prog_rst_no` = 1 and `done_o` = 1.
  - `rx_valid_i` is ignored.
  - `iccm_ctrl_we_o` stays 0.
- `restart_i` in DONE:
  - Next cycle: RECV, address 0, byte counter 0, `prog_rst_no` = 0, `done_o` = 0.
  - In any other state `restart_i` is ignored.
- `rst_i` asserted mid-word or mid-WRITE discards all partial state. Any in-progress write is dropped if `rst_i` is sampled high in that cycle.

## Timing
- Reset values: address 0, wdata 0, `iccm_ctrl_we_o` 0, `prog_rst_no` 0, `done_o` 0, `timeout_o` 0.
- Fourth byte accepted at cycle N:
  - `iccm_ctrl_we_o` = 1 at N+1.
  - Address shows the incremented value at N+2.
- End marker completed at cycle N: `prog_rst_no` and `done_o` rise at N+1.
- All outputs are registered; there is no combinational path from input to output.
- Sustained throughput: one byte per cycle, one write every 4 cycles.

## Configuration
- `ICCM_CTRL_TIMEOUT_EN` defined:
  - A counter runs in RECV while the byte counter is nonzero. It clears on each accepted byte.
  - On reaching `TimeoutCycles`: discard the partial word, set the byte counter to 0, pulse `timeout_o` for one cycle. State and address are unchanged.
- `ICCM_CTRL_TIMEOUT_EN` undefined: no counter; a partial word waits indefinitely and `timeout_o` is tied to 0.

## Structure
- Package `iccm_ctrl_pkg` holds:
  - the state enum `iccm_ctrl_state_e` (RECV, WRITE, DONE);
  - the default ICCM address width;
  - the default end-marker constant.
- Sub-module `iccm_word_assembler` contains the byte counter, lane shift and word-complete strobe, and the timeout counter when the macro is enabled. The top holds the FSM, the address counter and the output registers.

## Test plan
- Feed bytes 78 56 34 12 → `iccm_ctrl_we_o` pulse with address 0, data 0x12345678, `prog_rst_no` still 0.
- Feed three words, then FF 0F 00 00 → writes at 0, 1, 2; no fourth write; `done_o` = `prog_rst_no` = 1 one cycle after the last marker byte.
- Back-to-back bytes every cycle, including a byte during WRITE → every word is intact and the address increments by 1 per word.
- With AddrW = 2, send 5 words → writes at 0..3 only, DONE after the fourth, fifth word ignored; then `restart_i` → next word is written at address 0.
- Macro on, TimeoutCycles = 10: send 2 bytes, idle 10 cycles → `timeout_o` pulse. Then AA BB CC DD → data 0xDDCCBBAA at the same address.
- Assert `rst_i` after 2 bytes → all outputs at reset values; the next 4 bytes form a word written at address 0.
